// File: rtl/ag32gbd_capture_writer.sv
// ag32gbd_capture_writer
// Writes one captured frame of 256 pixel bytes into the frame-buffer port of
// the block-RAM controller. Incoming bytes queue in a small FIFO. Each byte is
// written with a single request/done handshake at offsets 0..255. After the
// last byte, FlipBuffer toggles so that the finished buffer becomes readable.
//
// Handshakes:
//   pixel side  : a byte transfers on a rising edge where PixelValid & PixelReady.
//   buffer side : RequestWriteBuffer is held, with data and offset stable, until
//                 a one-cycle BufferWriteDataDone. The request drops on that edge
//                 and stays low for at least one cycle before the next request.
//
// Optional feature: define CAPTURE_WRITER_TIMEOUT_EN to build a request watchdog.
// The watchdog abandons a write that is not acknowledged within TIMEOUT_CYCLES
// and raises a sticky WriteError.
module ag32gbd_capture_writer #(
  parameter int FIFO_DEPTH     = 4,
  parameter int TIMEOUT_CYCLES = 64
) (
  input  logic        sys_clock,
  input  logic        reset,
  input  logic        PixelValid,
  input  logic [7:0]  PixelData,
  output logic        PixelReady,
  input  logic        FrameStart,
  output logic        RequestWriteBuffer,
  output logic [7:0]  BufferWriteData,
  output logic [9:0]  BufferWriteOffset,
  input  logic        BufferWriteDataDone,
  output logic        FlipBuffer,
  output logic        FrameDone,
  output logic [15:0] FrameCount,
  output logic [7:0]  FramesDropped,
  output logic        WriteError,
  output logic [1:0]  fsm_state
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam logic [AW:0] DEPTH = (AW+1)'(FIFO_DEPTH);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_REQ  = 2'd1,
    S_FLIP = 2'd2
  } state_t;

  state_t        state, state_next;
  logic [7:0]    mem [FIFO_DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr, wr_idx;
  logic [AW:0]   count;
  logic [7:0]    offset;
  logic          pending;
  logic          push, pop, ack, advance, resync, flush, drop, timeout;

  assign push       = PixelValid && PixelReady;
  assign PixelReady = (count != DEPTH);
  assign fsm_state  = state;

  // A resync discards everything queued. The watchdog abort does the same.
  assign flush = resync || timeout;
  // Only a frame that has written some bytes counts as dropped.
  assign drop  = (resync && (offset != 8'd0)) || timeout;

  // State register
  always_ff @(posedge sys_clock or posedge reset) begin
    if (reset) state <= S_IDLE;
    else       state <= state_next;
  end

  // Next-state logic
  always_comb begin
    state_next = state;
    case (state)
      S_IDLE: if (pop) state_next = S_REQ;
      S_REQ: begin
        if (advance && (offset == 8'hFF)) state_next = S_FLIP;
        else if (ack || timeout)          state_next = S_IDLE;
      end
      S_FLIP:  state_next = S_IDLE;
      default: state_next = S_IDLE;
    endcase
  end

  // Per-state control strobes. In REQ, a FrameStart that is pending or arrives
  // with done replaces the offset step, so the frame restarts at offset 0.
  always_comb begin
    pop     = 1'b0;
    ack     = 1'b0;
    advance = 1'b0;
    resync  = 1'b0;
    case (state)
      S_IDLE: begin
        resync = FrameStart;
        pop    = !FrameStart && (count != '0);
      end
      S_REQ: begin
        ack     = BufferWriteDataDone;
        resync  = BufferWriteDataDone && (pending || FrameStart);
        advance = BufferWriteDataDone && !(pending || FrameStart);
      end
      S_FLIP:  resync = FrameStart;
      default: ;
    endcase
  end

  // On a flush, a byte accepted in the same cycle becomes the first entry of
  // the new frame.
  assign wr_idx = flush ? '0 : wr_ptr;

  // FIFO storage; contents need no reset because count gates every read
  always_ff @(posedge sys_clock) begin
    if (push) mem[wr_idx] <= PixelData;
  end

  // FIFO pointers and occupancy
  always_ff @(posedge sys_clock or posedge reset) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (flush) begin
      wr_ptr <= push ? AW'(1) : '0;
      rd_ptr <= '0;
      count  <= (AW+1)'(push);
    end else begin
      wr_ptr <= wr_ptr + AW'(push);
      rd_ptr <= rd_ptr + AW'(pop);
      count  <= count + (AW+1)'(push) - (AW+1)'(pop);
    end
  end

  // Request, frame offset, flip and statistics registers
  always_ff @(posedge sys_clock or posedge reset) begin
    if (reset) begin
      RequestWriteBuffer <= 1'b0;
      BufferWriteData    <= 8'd0;
      BufferWriteOffset  <= 10'd0;
      offset             <= 8'd0;
      pending            <= 1'b0;
      FlipBuffer         <= 1'b0;
      FrameDone          <= 1'b0;
      FrameCount         <= 16'd0;
      FramesDropped      <= 8'd0;
    end else begin
      if (pop) begin
        RequestWriteBuffer <= 1'b1;
        BufferWriteData    <= mem[rd_ptr];
        BufferWriteOffset  <= {2'b00, offset};
      end else if (ack || timeout) begin
        RequestWriteBuffer <= 1'b0;
      end
      if (flush)        offset <= 8'd0;
      else if (advance) offset <= offset + 8'd1;
      pending   <= (state == S_REQ) && (pending || FrameStart) && !ack && !timeout;
      FrameDone <= (state == S_FLIP);
      if (state == S_FLIP) begin
        FlipBuffer <= ~FlipBuffer;
        FrameCount <= FrameCount + 16'd1;
      end
      if (drop && (FramesDropped != 8'hFF)) FramesDropped <= FramesDropped + 8'd1;
    end
  end

`ifdef CAPTURE_WRITER_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT_CYCLES) + 1;
  logic [TW-1:0] wd_count;
  logic          write_error;

  assign timeout    = (state == S_REQ) && !BufferWriteDataDone &&
                      (wd_count == TW'(TIMEOUT_CYCLES - 1));
  assign WriteError = write_error;

  // Watchdog: counts unacknowledged cycles of the current request
  always_ff @(posedge sys_clock or posedge reset) begin
    if (reset)                                                  wd_count <= '0;
    else if ((state == S_REQ) && !BufferWriteDataDone && !timeout) wd_count <= wd_count + TW'(1);
    else                                                        wd_count <= '0;
  end

  // Sticky error flag; only reset clears it
  always_ff @(posedge sys_clock or posedge reset) begin
    if (reset)        write_error <= 1'b0;
    else if (timeout) write_error <= 1'b1;
  end
`else
  assign timeout    = 1'b0;
  // Without the watchdog, REQ waits forever and no error can occur. The
  // parameter is still referenced so both builds share one interface.
  assign WriteError = 1'b0 & (TIMEOUT_CYCLES != 0);
`endif

endmodule

// File: tb/tb_ag32gbd_capture_writer.sv
// Bench for ag32gbd_capture_writer. The reference model follows frames:
// each accepted byte gets the next index within its frame. A completed run of
// 256 bytes counts as one frame. A resync after a partial frame counts as a drop.
`timescale 1ns/1ps
module tb_ag32gbd_capture_writer;

  logic        sys_clock = 1'b0;
  logic        reset;
  logic        PixelValid;
  logic [7:0]  PixelData;
  logic        PixelReady;
  logic        FrameStart;
  logic        RequestWriteBuffer;
  logic [7:0]  BufferWriteData;
  logic [9:0]  BufferWriteOffset;
  logic        BufferWriteDataDone;
  logic        FlipBuffer;
  logic        FrameDone;
  logic [15:0] FrameCount;
  logic [7:0]  FramesDropped;
  logic        WriteError;
  logic [1:0]  fsm_state;

  ag32gbd_capture_writer #(.FIFO_DEPTH(4), .TIMEOUT_CYCLES(64)) dut (
    .sys_clock(sys_clock), .reset(reset),
    .PixelValid(PixelValid), .PixelData(PixelData), .PixelReady(PixelReady),
    .FrameStart(FrameStart),
    .RequestWriteBuffer(RequestWriteBuffer), .BufferWriteData(BufferWriteData),
    .BufferWriteOffset(BufferWriteOffset), .BufferWriteDataDone(BufferWriteDataDone),
    .FlipBuffer(FlipBuffer), .FrameDone(FrameDone), .FrameCount(FrameCount),
    .FramesDropped(FramesDropped), .WriteError(WriteError), .fsm_state(fsm_state)
  );

  // ---------------- clock / safety net ----------------
  always #5 sys_clock = ~sys_clock;

  initial begin
    #1000000;
    $display("FAIL global_timeout: got no end of test, expected completion");
    $fatal(1);
  end

  // ---------------- scoreboard state ----------------
  int          n_vec = 0;
  int          n_fail = 0;
  logic [17:0] exp_q[$];     // {offset[9:0], data[7:0]} in write order
  logic [7:0]  model_off;    // index of the next byte within the current frame
  int          exp_frames, exp_dropped, fd_seen;
  logic        exp_werr;
  bit          ctl_en;
  int          ctl_min, ctl_max;
  logic        req_prev, fd_prev;
  logic [17:0] held;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_resync();
    if (model_off != 8'd0) exp_dropped = (exp_dropped < 255) ? exp_dropped + 1 : 255;
    model_off = 8'd0;
  endtask

  task automatic model_byte(input logic [7:0] d);
    exp_q.push_back({2'b00, model_off, d});
    model_off = model_off + 8'd1;
    if (model_off == 8'd0) exp_frames++;
  endtask

  task automatic model_clear();
    exp_q.delete();
    model_off   = 8'd0;
    exp_frames  = 0;
    exp_dropped = 0;
    fd_seen     = 0;
    exp_werr    = 1'b0;
  endtask

  // ---------------- controller model ----------------
  // Acknowledges each request after a random number of cycles (when enabled).
  always begin
    int d;
    int k;
    @(negedge sys_clock);
    if (RequestWriteBuffer && ctl_en && !reset) begin
      d = int'($urandom_range(ctl_max, ctl_min));
      k = 0;
      while ((k < d) && RequestWriteBuffer) begin
        @(negedge sys_clock);
        k++;
      end
      if (RequestWriteBuffer) begin
        BufferWriteDataDone = 1'b1;
        @(negedge sys_clock);
        BufferWriteDataDone = 1'b0;
      end
    end
  end

  // ---------------- write monitor ----------------
  always @(negedge sys_clock) begin
    logic [17:0] e;
    if (reset) begin
      req_prev = 1'b0;
      fd_prev  = 1'b0;
    end else begin
      if (RequestWriteBuffer && !req_prev) begin
        held = {BufferWriteOffset, BufferWriteData};
        if (exp_q.size() == 0) begin
          check("unexpected_req", 32'(held), 32'h3ffff);
        end else begin
          e = exp_q.pop_front();
          check("write_off_data", 32'(held), 32'(e));
        end
      end else if (RequestWriteBuffer) begin
        check("hold_stable", 32'({BufferWriteOffset, BufferWriteData}), 32'(held));
      end
      if (FrameDone) begin
        fd_seen++;
        if (fd_prev) check("framedone_width", 32'(2), 32'(1));
      end
      req_prev = RequestWriteBuffer;
      fd_prev  = FrameDone;
    end
  end

  // ---------------- driver tasks ----------------
  // Called at a falling edge; returns at the falling edge after the transfer.
  task automatic push_byte(input logic [7:0] d, input bit fs);
    bit rdy;
    int waited;
    waited     = 0;
    rdy        = 1'b0;
    PixelValid = 1'b1;
    PixelData  = d;
    FrameStart = fs;
    if (fs) model_resync();
    forever begin
      rdy = PixelReady;
      @(negedge sys_clock);
      FrameStart = 1'b0;
      if (rdy) break;
      waited++;
      if (waited > 500) begin
        check("push_timeout", 32'(0), 32'(1));
        break;
      end
    end
    PixelValid = 1'b0;
    if (rdy) model_byte(d);
  endtask

  task automatic fs_pulse(input bit upd_model);
    FrameStart = 1'b1;
    if (upd_model) model_resync();
    @(negedge sys_clock);
    FrameStart = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge sys_clock);
  endtask

  task automatic push_random(input int n, input int gap_max);
    for (int i = 0; i < n; i++) begin
      push_byte(8'($urandom_range(255, 0)), 1'b0);
      idle(int'($urandom_range(gap_max, 0)));
    end
  endtask

  task automatic quiesce();
    int t;
    t = 0;
    while (((exp_q.size() != 0) || RequestWriteBuffer) && (t < 4000)) begin
      @(negedge sys_clock);
      t++;
    end
    check("quiesce_in_time", 32'(t < 4000), 32'(1));
    idle(3);
  endtask

  task automatic wait_req();
    int t;
    t = 0;
    while (!RequestWriteBuffer && (t < 100)) begin
      @(negedge sys_clock);
      t++;
    end
    check("req_seen", 32'(RequestWriteBuffer), 32'(1));
  endtask

  task automatic check_totals();
    check("frame_count", 32'(FrameCount), 32'(exp_frames[15:0]));
    check("flip_buffer", 32'(FlipBuffer), 32'(exp_frames[0]));
    check("frame_done_pulses", 32'(fd_seen), 32'(exp_frames));
    check("frames_dropped", 32'(FramesDropped), 32'(exp_dropped));
    check("write_error", 32'(WriteError), 32'(exp_werr));
  endtask

  task automatic check_reset_values(input string tag);
    check({tag, "_req"}, 32'(RequestWriteBuffer), 32'(0));
    check({tag, "_data"}, 32'(BufferWriteData), 32'(0));
    check({tag, "_offset"}, 32'(BufferWriteOffset), 32'(0));
    check({tag, "_flip"}, 32'(FlipBuffer), 32'(0));
    check({tag, "_framedone"}, 32'(FrameDone), 32'(0));
    check({tag, "_framecount"}, 32'(FrameCount), 32'(0));
    check({tag, "_dropped"}, 32'(FramesDropped), 32'(0));
    check({tag, "_werr"}, 32'(WriteError), 32'(0));
    check({tag, "_ready"}, 32'(PixelReady), 32'(1));
  endtask

  // ---------------- main sequence ----------------
  initial begin
    int stuck_hi;
    int r;
    reset = 1'b1;
    PixelValid = 1'b0;
    PixelData = 8'd0;
    FrameStart = 1'b0;
    BufferWriteDataDone = 1'b0;
    ctl_en = 1'b1;
    ctl_min = 0;
    ctl_max = 3;
    model_clear();
    idle(3);
    check_reset_values("rst");
    reset = 1'b0;
    idle(2);

    // Full frame 0x00..0xFF with first-byte latency check
    fs_pulse(1'b1);
    push_byte(8'h00, 1'b0);
    check("latency_edge_n", 32'(RequestWriteBuffer), 32'(0));
    @(negedge sys_clock);
    check("latency_edge_n1", 32'(RequestWriteBuffer), 32'(1));
    for (int i = 1; i < 256; i++) begin
      push_byte(8'(i), 1'b0);
      idle(int'($urandom_range(2, 0)));
    end
    quiesce();
    check_totals();

    // Abort after 100 bytes, then the next byte lands at offset 0
    push_random(100, 2);
    quiesce();
    fs_pulse(1'b1);
    push_byte(8'($urandom_range(255, 0)), 1'b0);
    quiesce();
    check_totals();

    // Backpressure: slow controller, back-to-back bytes
    ctl_min = 10;
    ctl_max = 10;
    for (int i = 0; i < 5; i++) push_byte(8'($urandom_range(255, 0)), 1'b0);
    check("backpressure_ready", 32'(PixelReady), 32'(0));
    for (int i = 0; i < 3; i++) push_byte(8'($urandom_range(255, 0)), 1'b0);
    quiesce();
    check_totals();

    // FrameStart in the same cycle as an accepted byte
    ctl_min = 0;
    ctl_max = 3;
    push_byte(8'($urandom_range(255, 0)), 1'b1);
    push_random(3, 1);
    quiesce();
    check_totals();

    // FrameStart while a write is outstanding; byte in flight is at offset 4
    ctl_min = 8;
    ctl_max = 8;
    push_byte(8'($urandom_range(255, 0)), 1'b0);
    wait_req();
    fs_pulse(1'b0);
    model_resync();
    ctl_min = 0;
    ctl_max = 3;
    quiesce();
    push_byte(8'($urandom_range(255, 0)), 1'b0);
    quiesce();
    check_totals();

    // Random segments with resyncs at quiet points
    for (int s = 0; s < 6; s++) begin
      ctl_max = int'($urandom_range(4, 0));
      r = int'($urandom_range(2, 0));
      if (r == 1) fs_pulse(1'b1);
      if (r == 2) push_byte(8'($urandom_range(255, 0)), 1'b1);
      push_random(int'($urandom_range(300, 1)), 2);
      quiesce();
      check_totals();
    end

    // Controller that never acknowledges
    ctl_en = 1'b0;
    push_byte(8'($urandom_range(255, 0)), 1'b0);
    wait_req();
    stuck_hi = 0;
`ifdef CAPTURE_WRITER_TIMEOUT_EN
    while (RequestWriteBuffer && (stuck_hi < 200)) begin
      @(negedge sys_clock);
      stuck_hi++;
    end
    check("watchdog_cycles", 32'(stuck_hi), 32'(64));
    exp_werr = 1'b1;
    exp_dropped = (exp_dropped < 255) ? exp_dropped + 1 : 255;
    model_off = 8'd0;
    idle(2);
    check_totals();
    push_byte(8'($urandom_range(255, 0)), 1'b0);
    wait_req();
`else
    for (int i = 0; i < 1000; i++) begin
      @(negedge sys_clock);
      if (RequestWriteBuffer) stuck_hi++;
    end
    check("stuck_req_cycles", 32'(stuck_hi), 32'(1000));
    check_totals();
`endif

    // Asynchronous reset while the request is high
    #1;
    reset = 1'b1;
    #1;
    check_reset_values("async_rst");
    @(negedge sys_clock);
    reset = 1'b0;
    model_clear();
    ctl_en = 1'b1;
    ctl_max = 3;
    idle(2);
    push_random(20, 2);
    quiesce();
    check_totals();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule
